scratch_buffer: RTL and testbench
=================================

Name: scratch_buffer

Overview:
On-chip line buffer that sits directly in front of the transposer and serves its read and write streams.
- Read stream: raddr/raddr_vld in, rdata/rdata_vld out.
- Write stream: waddr/wdata/wdata_vld in.
- A secondary external (DMA) port loads operands before a run and dumps results after it.
- The transposer has no stall input, so its accesses always win. The external port yields through a ready signal.

Parameters:
AW, 16, address width of all ports
BUFFD, 64, line width in bytes; data buses are BUFFD*8 bits
DEPTH, 256, number of lines; index = addr[$clog2(DEPTH)-1:0]
RD_LAT, 2, read latency in cycles from accepted request to response valid; legal range >= 1

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
init_pulse  input  1  clears the sticky addr_err flag
raddr  input  AW  transposer read line address
raddr_vld  input  1  transposer read request; always accepted
rdata  output  BUFFD*8  transposer read data
rdata_vld  output  1  transposer read data valid
waddr  input  AW  transposer write line address
wdata  input  BUFFD*8  transposer write data
wdata_vld  input  1  transposer write; always accepted
ext_req_vld  input  1  external request valid
ext_req_we  input  1  1 = write, 0 = read
ext_req_addr  input  AW  external line address
ext_req_wdata  input  BUFFD*8  external write data
ext_req_rdy  output  1  external request accepted this cycle when high with ext_req_vld
ext_rsp_data  output  BUFFD*8  external read data
ext_rsp_vld  output  1  external read data valid
addr_err  output  1  sticky out-of-range address flag

Behaviour:
- Storage: DEPTH x BUFFD*8 array with no reset; contents survive reset_n.
- Port structure: one read port and one write port per cycle.
- External ready: ext_req_rdy = ext_req_we ? !wdata_vld : !raddr_vld. This is combinational.
  - An external write is blocked only by a transposer write.
  - An external read is blocked only by a transposer read.
- Read timing: the array is sampled in the accept cycle t. The response appears at t+RD_LAT.
  - The pipeline carries {vld, src, data}. src selects rdata_vld or ext_rsp_vld.
  - Responses return in order, with at most one read per cycle.
- Output valids are 1-cycle pulses. rdata and ext_rsp_data hold their last value when not valid.
- Out of range: an accepted access with addr >= DEPTH (addr compared at full AW width) sets addr_err.
  - A write to such an address is dropped.
  - A read to such an address still produces its valid pulse, with data = 0.
- Error clear: addr_err is cleared by init_pulse. If a new error and init_pulse occur in the same cycle, the set wins.
- Same-cycle read and write to the same index: the read returns the OLD contents (read-before-write). See the optional feature for the alternative.
- Backpressure: a transposer and an external request of the same type in the same cycle leave ext_req_rdy=0. The external request must stay held; it is not queued.
- Reset (async assert, any time):
  - all pipeline vld bits, rdata_vld, ext_rsp_vld, ext_req_rdy-internal state and addr_err go to 0;
  - rdata and ext_rsp_data go to 0;
  - in-flight responses are discarded.
- Back-to-back reads every cycle are sustained indefinitely; there is no bubble.

Optional Feature:
SCRATCH_WR_BYPASS_EN:
- Defined: a read accepted in the same cycle as a write to the same in-range index returns the new write data. The transposer write has priority over an external write to the same index.
- Undefined: read-before-write as described above; no forwarding mux is built.

Decomposition:
- Package scratch_pkg:
  - line_t (logic [BUFFD*8-1:0]);
  - src_e enum {SRC_XPOSE, SRC_EXT};
  - rd_entry_t struct {vld, src, line_t data};
  - function in_range(addr).
- Sub-module scratch_rd_pipe: a parameterized RD_LAT-stage shift register of rd_entry_t with async reset of the vld bits. The top level holds the array, the arbitration, error logic and output demux.

Test Plan:
- Write/read: ext write addr 5 = 0xA5 pattern, then transposer raddr 5 at t -> rdata_vld=1 at t+2 with 0xA5 pattern; ext_rsp_vld stays 0.
- Conflict: raddr_vld=1 and ext read addr 7 in the same cycle -> ext_req_rdy=0. Ext read to addr 7 the next cycle -> ext_rsp_vld at accept+2 with the stored line.
- Same-cycle same index: wdata=0x11.. to addr 3 while raddr=3 (old 0x22..) -> rdata=0x22.. without the macro, 0x11.. with SCRATCH_WR_BYPASS_EN.
- Out of range: ext write addr 300 -> addr_err=1 and no line modified. Transposer read addr 256 -> rdata_vld with data 0. init_pulse -> addr_err=0.
- Streaming: 64 consecutive raddr_vld cycles, addr 0..63 -> 64 consecutive rdata_vld pulses, in order, starting at cycle 2.
- Reset mid-run: reads issued at t and t+1, reset_n low at t+1 -> no valid pulses after reset. Memory still holds the preloaded lines on reread.

Source files
------------

// File: rtl/scratch_pkg.sv
// scratch_pkg: shared sizing, line/entry types and address range check for the scratch line buffer.
package scratch_pkg;
  localparam int AW = 16;
  localparam int BUFFD = 64;
  localparam int DEPTH = 256;
  localparam int RD_LAT_DEF = 2;
  typedef logic [BUFFD*8-1:0] line_t;
  typedef enum logic {SRC_XPOSE, SRC_EXT} src_e;
  typedef struct packed {
    logic  vld;
    src_e  src;
    line_t data;
  } rd_entry_t;
  function automatic logic in_range(input logic [AW-1:0] addr);
    return addr < AW'(DEPTH);
  endfunction
endpackage

// File: rtl/scratch_rd_pipe.sv
// scratch_rd_pipe: RD_LAT-stage read response delay line; only the valid bits are reset.
module scratch_rd_pipe
  import scratch_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic      clk,
  input  logic      reset_n,
  input  rd_entry_t in_i,
  output rd_entry_t out_o
);
  logic [RD_LAT-1:0] vld_q;
  src_e              src_q  [RD_LAT];
  line_t             data_q [RD_LAT];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) vld_q <= '0;
    else begin
      vld_q[0] <= in_i.vld;
      for (int k = 1; k < RD_LAT; k++) vld_q[k] <= vld_q[k-1];
    end
  always_ff @(posedge clk) begin
    src_q[0]  <= in_i.src;
    data_q[0] <= in_i.data;
    for (int k = 1; k < RD_LAT; k++) begin
      src_q[k]  <= src_q[k-1];
      data_q[k] <= data_q[k-1];
    end
  end
  assign out_o = '{vld: vld_q[RD_LAT-1], src: src_q[RD_LAT-1], data: data_q[RD_LAT-1]};
endmodule

// File: rtl/scratch_buffer.sv
// scratch_buffer: line buffer in front of the transposer; transposer accesses always win, the external port yields via ext_req_rdy.
// Optional SCRATCH_WR_BYPASS_EN forwards same-cycle write data to a read of the same in-range line.
module scratch_buffer
  import scratch_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 init_pulse,
  input  logic [AW-1:0]        raddr,
  input  logic                 raddr_vld,
  output logic [BUFFD*8-1:0]   rdata,
  output logic                 rdata_vld,
  input  logic [AW-1:0]        waddr,
  input  logic [BUFFD*8-1:0]   wdata,
  input  logic                 wdata_vld,
  input  logic                 ext_req_vld,
  input  logic                 ext_req_we,
  input  logic [AW-1:0]        ext_req_addr,
  input  logic [BUFFD*8-1:0]   ext_req_wdata,
  output logic                 ext_req_rdy,
  output logic [BUFFD*8-1:0]   ext_rsp_data,
  output logic                 ext_rsp_vld,
  output logic                 addr_err
);
  localparam int IW = $clog2(DEPTH);
  line_t     mem_q [DEPTH];
  logic      ext_acc, wr_en, rd_en, err_set, err_d, err_q;
  logic [AW-1:0] wr_addr, rd_addr;
  line_t     wr_data, rd_line, rdata_d, rdata_q, ext_d, ext_q;
  src_e      rd_src;
  rd_entry_t pipe_in, pipe_out;
  assign ext_req_rdy = ext_req_we ? !wdata_vld : !raddr_vld;
  assign ext_acc = ext_req_vld && ext_req_rdy;
  // At most one write and one read per cycle: the external port only gets a slot the transposer left free.
  always_comb begin
    wr_addr = wdata_vld ? waddr : ext_req_addr;
    wr_data = wdata_vld ? wdata : ext_req_wdata;
    wr_en   = (wdata_vld || (ext_acc && ext_req_we)) && in_range(wr_addr);
    rd_addr = raddr_vld ? raddr : ext_req_addr;
    rd_src  = raddr_vld ? SRC_XPOSE : SRC_EXT;
    rd_en   = raddr_vld || (ext_acc && !ext_req_we);
`ifdef SCRATCH_WR_BYPASS_EN
    rd_line = !in_range(rd_addr) ? '0 :
              (wr_en && wr_addr[IW-1:0] == rd_addr[IW-1:0]) ? wr_data : mem_q[rd_addr[IW-1:0]];
`else
    rd_line = in_range(rd_addr) ? mem_q[rd_addr[IW-1:0]] : '0;
`endif
    err_set = (raddr_vld && !in_range(raddr)) || (wdata_vld && !in_range(waddr)) ||
              (ext_acc && !in_range(ext_req_addr));
    err_d   = err_set || (err_q && !init_pulse);
  end
  assign pipe_in = '{vld: rd_en, src: rd_src, data: rd_line};
  scratch_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk(clk), .reset_n(reset_n), .in_i(pipe_in), .out_o(pipe_out)
  );
  assign rdata_vld    = pipe_out.vld && pipe_out.src == SRC_XPOSE;
  assign ext_rsp_vld  = pipe_out.vld && pipe_out.src == SRC_EXT;
  assign rdata_d      = rdata_vld ? pipe_out.data : rdata_q;
  assign ext_d        = ext_rsp_vld ? pipe_out.data : ext_q;
  assign rdata        = rdata_d;
  assign ext_rsp_data = ext_d;
  assign addr_err     = err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rdata_q <= '0;
      ext_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_addr[IW-1:0]] <= wr_data;
endmodule

// File: tb/tb_scratch_buffer.sv
// tb_scratch_buffer: randomized and directed checks of scratch_buffer against a line-array/response-queue model.
module tb_scratch_buffer;
  import scratch_pkg::*;
  logic clk = 0, reset_n = 0, init_pulse = 0;
  logic [AW-1:0] raddr = 0, waddr = 0, ext_req_addr = 0;
  logic raddr_vld = 0, wdata_vld = 0, ext_req_vld = 0, ext_req_we = 0;
  line_t wdata = '0, ext_req_wdata = '0, rdata, ext_rsp_data;
  logic rdata_vld, ext_rsp_vld, ext_req_rdy, addr_err;
  int n_cmp = 0, n_err = 0, cyc = 0;
  typedef struct {int due; logic ext; line_t data;} rsp_t;
  line_t mdl [DEPTH];
  rsp_t pend [$];
  logic e_rvld = 0, e_xvld = 0, e_err = 0, e_rdy = 0;
  line_t e_rdata = '0, e_xdata = '0;

  scratch_buffer dut (
    .clk(clk), .reset_n(reset_n), .init_pulse(init_pulse),
    .raddr(raddr), .raddr_vld(raddr_vld), .rdata(rdata), .rdata_vld(rdata_vld),
    .waddr(waddr), .wdata(wdata), .wdata_vld(wdata_vld),
    .ext_req_vld(ext_req_vld), .ext_req_we(ext_req_we), .ext_req_addr(ext_req_addr),
    .ext_req_wdata(ext_req_wdata), .ext_req_rdy(ext_req_rdy),
    .ext_rsp_data(ext_rsp_data), .ext_rsp_vld(ext_rsp_vld), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic line_t rnd_line();
    line_t l;
    for (int i = 0; i < BUFFD / 4; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic set_idle();
    raddr_vld = 0; wdata_vld = 0; ext_req_vld = 0; ext_req_we = 0; init_pulse = 0;
  endtask

  task automatic model_reset();
    pend.delete();
    e_rvld = 0; e_xvld = 0; e_err = 0; e_rdata = '0; e_xdata = '0;
  endtask

  // Apply the current inputs for one clock, advance the model, and leave expectations for the new cycle.
  task automatic cycle();
    logic acc, wen, den, dext, set;
    logic [AW-1:0] wa, ra;
    line_t wd, rd;
    rsp_t r;
    #1;
    e_rdy = ext_req_we ? !wdata_vld : !raddr_vld;
    acc = ext_req_vld && e_rdy;
    wen = wdata_vld || (acc && ext_req_we);
    wa = wdata_vld ? waddr : ext_req_addr;
    wd = wdata_vld ? wdata : ext_req_wdata;
    den = raddr_vld || (acc && !ext_req_we);
    dext = !raddr_vld;
    ra = raddr_vld ? raddr : ext_req_addr;
    rd = (ra < DEPTH) ? mdl[ra] : '0;
`ifdef SCRATCH_WR_BYPASS_EN
    if (wen && wa == ra && ra < DEPTH) rd = wd;
`endif
    if (wen && wa < DEPTH) mdl[wa] = wd;
    set = (raddr_vld && raddr >= DEPTH) || (wdata_vld && waddr >= DEPTH) || (acc && ext_req_addr >= DEPTH);
    e_err = set || (e_err && !init_pulse);
    if (den) pend.push_back('{cyc + RD_LAT_DEF, dext, rd});
    @(posedge clk); #1; cyc++;
    e_rvld = 0; e_xvld = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.ext) begin e_xvld = 1; e_xdata = r.data; end
      else begin e_rvld = 1; e_rdata = r.data; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (rdata_vld !== 1'b0) begin n_err++; $display("FAIL rst_rdata_vld: got %b exp 0", rdata_vld); end
    n_cmp++; if (ext_rsp_vld !== 1'b0) begin n_err++; $display("FAIL rst_ext_rsp_vld: got %b exp 0", ext_rsp_vld); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL rst_addr_err: got %b exp 0", addr_err); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL rst_rdata: got %h exp 0", rdata); end
    n_cmp++; if (ext_rsp_data !== '0) begin n_err++; $display("FAIL rst_ext_rsp_data: got %h exp 0", ext_rsp_data); end
    reset_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      wdata_vld = 1; waddr = AW'(i); wdata = rnd_line();
      cycle();
    end
    set_idle();
    repeat (2) cycle();
  endtask

  task automatic test_write_read();
    line_t a5 = {BUFFD{8'hA5}};
    set_idle(); ext_req_vld = 1; ext_req_we = 1; ext_req_addr = 5; ext_req_wdata = a5;
    #1;
    n_cmp++; if (ext_req_rdy !== 1'b1) begin n_err++; $display("FAIL wr_ext_rdy: got %b exp 1", ext_req_rdy); end
    cycle();
    set_idle(); raddr_vld = 1; raddr = 5;
    cycle();
    n_cmp++; if (rdata_vld !== 1'b0) begin n_err++; $display("FAIL wr_rd_early: got %b exp 0", rdata_vld); end
    set_idle();
    cycle();
    n_cmp++; if (rdata_vld !== 1'b1) begin n_err++; $display("FAIL wr_rd_vld: got %b exp 1", rdata_vld); end
    n_cmp++; if (rdata !== a5) begin n_err++; $display("FAIL wr_rd_data: got %h exp %h", rdata, a5); end
    n_cmp++; if (ext_rsp_vld !== 1'b0) begin n_err++; $display("FAIL wr_rd_ext_vld: got %b exp 0", ext_rsp_vld); end
    cycle();
    n_cmp++; if (rdata_vld !== 1'b0) begin n_err++; $display("FAIL wr_rd_pulse: got %b exp 0", rdata_vld); end
    n_cmp++; if (rdata !== a5) begin n_err++; $display("FAIL wr_rd_hold: got %h exp %h", rdata, a5); end
  endtask

  task automatic test_conflict();
    line_t l7 = mdl[7], l9 = mdl[9];
    set_idle(); raddr_vld = 1; raddr = 9; ext_req_vld = 1; ext_req_we = 0; ext_req_addr = 7;
    #1;
    n_cmp++; if (ext_req_rdy !== 1'b0) begin n_err++; $display("FAIL cf_rdy_blocked: got %b exp 0", ext_req_rdy); end
    cycle();
    raddr_vld = 0;
    #1;
    n_cmp++; if (ext_req_rdy !== 1'b1) begin n_err++; $display("FAIL cf_rdy_free: got %b exp 1", ext_req_rdy); end
    cycle();
    set_idle();
    n_cmp++; if (rdata_vld !== 1'b1 || rdata !== l9) begin n_err++; $display("FAIL cf_xpose_rsp: got %b/%h exp 1/%h", rdata_vld, rdata, l9); end
    n_cmp++; if (ext_rsp_vld !== 1'b0) begin n_err++; $display("FAIL cf_ext_early: got %b exp 0", ext_rsp_vld); end
    cycle();
    n_cmp++; if (ext_rsp_vld !== 1'b1 || ext_rsp_data !== l7) begin n_err++; $display("FAIL cf_ext_rsp: got %b/%h exp 1/%h", ext_rsp_vld, ext_rsp_data, l7); end
    n_cmp++; if (rdata_vld !== 1'b0 || rdata !== l9) begin n_err++; $display("FAIL cf_rdata_hold: got %b/%h exp 0/%h", rdata_vld, rdata, l9); end
    cycle();
  endtask

  task automatic test_same_index();
    line_t exp;
`ifdef SCRATCH_WR_BYPASS_EN
    exp = {BUFFD{8'h11}};
`else
    exp = {BUFFD{8'h22}};
`endif
    set_idle(); wdata_vld = 1; waddr = 3; wdata = {BUFFD{8'h22}};
    cycle();
    wdata = {BUFFD{8'h11}}; raddr_vld = 1; raddr = 3;
    cycle();
    set_idle();
    cycle();
    n_cmp++; if (rdata_vld !== 1'b1 || rdata !== exp) begin n_err++; $display("FAIL same_idx: got %b/%h exp 1/%h", rdata_vld, rdata, exp); end
    raddr_vld = 1; raddr = 3;
    cycle();
    set_idle();
    cycle();
    n_cmp++; if (rdata !== {BUFFD{8'h11}}) begin n_err++; $display("FAIL same_idx_after: got %h exp 11..", rdata); end
  endtask

  task automatic test_out_of_range();
    line_t old = mdl[44];
    set_idle(); ext_req_vld = 1; ext_req_we = 1; ext_req_addr = 300; ext_req_wdata = rnd_line();
    cycle();
    set_idle();
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_err_set: got %b exp 1", addr_err); end
    raddr_vld = 1; raddr = 44;
    cycle();
    raddr = 256;
    cycle();
    set_idle();
    n_cmp++; if (rdata_vld !== 1'b1 || rdata !== old) begin n_err++; $display("FAIL oor_no_alias: got %b/%h exp 1/%h", rdata_vld, rdata, old); end
    cycle();
    n_cmp++; if (rdata_vld !== 1'b1 || rdata !== '0) begin n_err++; $display("FAIL oor_rd_zero: got %b/%h exp 1/0", rdata_vld, rdata); end
    init_pulse = 1; raddr_vld = 1; raddr = 1000;
    cycle();
    set_idle();
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_set_wins: got %b exp 1", addr_err); end
    init_pulse = 1;
    cycle();
    set_idle();
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL oor_clear: got %b exp 0", addr_err); end
    repeat (2) cycle();
  endtask

  task automatic test_streaming();
    int cnt = 0;
    for (int i = 0; i < 66; i++) begin
      if (i < 64) begin raddr_vld = 1; raddr = AW'(i); end
      else set_idle();
      cycle();
      if (rdata_vld === 1'b1) cnt++;
      if (i >= 1 && i <= 64) begin
        n_cmp++; if (rdata_vld !== 1'b1 || rdata !== mdl[i-1]) begin n_err++; $display("FAIL stream_%0d: got %b/%h exp 1/%h", i - 1, rdata_vld, rdata, mdl[i-1]); end
      end
    end
    n_cmp++; if (cnt != 64) begin n_err++; $display("FAIL stream_count: got %0d exp 64", cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      raddr_vld = ($urandom_range(0, 2) != 0); raddr = AW'($urandom_range(0, 299));
      wdata_vld = ($urandom_range(0, 2) == 0); waddr = AW'($urandom_range(0, 279)); wdata = rnd_line();
      ext_req_vld = $urandom_range(0, 1); ext_req_we = $urandom_range(0, 1);
      ext_req_addr = AW'($urandom_range(0, 279)); ext_req_wdata = rnd_line();
      init_pulse = ($urandom_range(0, 15) == 0);
      #1;
      n_cmp++; if (ext_req_rdy !== (ext_req_we ? !wdata_vld : !raddr_vld)) begin n_err++; $display("FAIL rnd_rdy@%0d: got %b", cyc, ext_req_rdy); end
      cycle();
      n_cmp++; if (rdata_vld !== e_rvld) begin n_err++; $display("FAIL rnd_rvld@%0d: got %b exp %b", cyc, rdata_vld, e_rvld); end
      n_cmp++; if (rdata !== e_rdata) begin n_err++; $display("FAIL rnd_rdata@%0d: got %h exp %h", cyc, rdata, e_rdata); end
      n_cmp++; if (ext_rsp_vld !== e_xvld) begin n_err++; $display("FAIL rnd_xvld@%0d: got %b exp %b", cyc, ext_rsp_vld, e_xvld); end
      n_cmp++; if (ext_rsp_data !== e_xdata) begin n_err++; $display("FAIL rnd_xdata@%0d: got %h exp %h", cyc, ext_rsp_data, e_xdata); end
      n_cmp++; if (addr_err !== e_err) begin n_err++; $display("FAIL rnd_err@%0d: got %b exp %b", cyc, addr_err, e_err); end
    end
    set_idle(); init_pulse = 1;
    cycle();
    set_idle();
    repeat (2) cycle();
  endtask

  task automatic test_reset_mid_run();
    line_t l10 = mdl[10];
    set_idle(); raddr_vld = 1; raddr = 10;
    cycle();
    raddr = 11;
    #2 reset_n = 0;
    model_reset();
    @(posedge clk); #1; cyc++;
    n_cmp++; if (rdata_vld !== 1'b0 || rdata !== '0) begin n_err++; $display("FAIL mid_rst_out: got %b/%h exp 0/0", rdata_vld, rdata); end
    set_idle();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (rdata_vld !== 1'b0 || ext_rsp_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_quiet_%0d: got %b/%b exp 0/0", i, rdata_vld, ext_rsp_vld); end
    end
    raddr_vld = 1; raddr = 10;
    cycle();
    set_idle();
    cycle();
    n_cmp++; if (rdata_vld !== 1'b1 || rdata !== l10) begin n_err++; $display("FAIL mid_rst_reread: got %b/%h exp 1/%h", rdata_vld, rdata, l10); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_same_index();
    test_out_of_range();
    test_streaming();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
